// File: rtl/cnn_conv_tap_accum.sv
// Sums KERNEL_LEN multiplier products into one conv sample on a valid/ready output.
// Define CNN_ACC_SAT_EN to saturate on overflow and raise the sticky acc_ovf flag.
module cnn_conv_tap_accum #(
  parameter int PROD_W     = 11,
  parameter int KERNEL_LEN = 5,
  parameter int ACC_W      = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          clear,
  input  logic [PROD_W-1:0]             prod_data,
  input  logic                          prod_valid,
  output logic                          prod_ready,
  output logic [ACC_W-1:0]              acc_data,
  output logic                          acc_valid,
  input  logic                          acc_ready,
  output logic [$clog2(KERNEL_LEN)-1:0] tap_idx,
  output logic                          acc_ovf
);

  localparam int TAP_W = $clog2(KERNEL_LEN);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_LEN - 1);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt_acc;
  logic             in_beat;
  logic             out_beat;

  assign acc_valid  = (state == HOLD);
  assign prod_ready = !acc_valid | acc_ready;
  assign in_beat    = prod_valid & prod_ready;
  assign out_beat   = acc_valid & acc_ready;

`ifdef CNN_ACC_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf_evt;

  assign sum     = {1'b0, acc} + (ACC_W+1)'(prod_data);
  assign ovf_evt = sum[ACC_W];
  // Clamped acc stays at max for the rest of the sample
  assign nxt_acc = ovf_evt ? '1 : sum[ACC_W-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_ovf <= 1'b0;
    end else if (!clear && in_beat && ovf_evt) begin
      acc_ovf <= 1'b1;
    end
  end
`else
  assign nxt_acc = acc + ACC_W'(prod_data);
  assign acc_ovf = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      tap_idx  <= '0;
      acc_data <= '0;
    end else if (clear) begin
      state   <= ACCUM;
      acc     <= '0;
      tap_idx <= '0;
    end else begin
      if (out_beat) begin
        state <= ACCUM;
      end
      if (in_beat) begin
        if (tap_idx == LAST_TAP) begin
          acc_data <= nxt_acc;
          state    <= HOLD;
          acc      <= '0;
          tap_idx  <= '0;
        end else begin
          acc     <= nxt_acc;
          tap_idx <= tap_idx + TAP_W'(1);
        end
      end
    end
  end

endmodule
